// File: rtl/alu_exec_unit.sv
// alu_exec_unit: single-entry sequential ALU execution unit.
// Accepts Operation/A/B over a valid/ready handshake and returns Result,
// Zero and Overflow over a second valid/ready handshake.
// Build option: define ALU_SERIAL_SHIFT_EN to run SLL/SRL one bit per cycle
// through the SHIFT state instead of using a single-cycle barrel shifter.
module alu_exec_unit #(
  parameter int WIDTH = 16
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             InValid,
  output logic             InReady,
  input  logic [3:0]       Operation,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] Result,
  output logic             Zero,
  output logic             Overflow
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_SLTI = 4'b0001;
  localparam logic [3:0] OP_OR   = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_ADD  = 4'b0100;
  localparam logic [3:0] OP_ADDI = 4'b0101;
  localparam logic [3:0] OP_SLL  = 4'b0110;
  localparam logic [3:0] OP_SRL  = 4'b0111;
  localparam logic [3:0] OP_SUB  = 4'b1100;
  localparam logic [3:0] OP_SUBI = 4'b1101;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic             valid_reg, valid_next;
  logic [WIDTH-1:0] result_reg, result_next;
  logic             zero_reg, zero_next;
  logic             ovf_reg, ovf_next;

  logic [WIDTH-1:0] sum, diff, calc_result;
  logic             calc_ovf;
  logic [SHW-1:0]   shamt;
  logic             accept;
  logic             shift_start;

  assign shamt    = B[SHW-1:0];
  assign InReady  = (state_reg == IDLE) || ((state_reg == DONE) && OutReady);
  assign accept   = InValid && InReady;
  assign OutValid = valid_reg;
  assign Result   = result_reg;
  assign Zero     = zero_reg;
  assign Overflow = ovf_reg;

`ifdef ALU_SERIAL_SHIFT_EN
  logic [SHW-1:0] cnt_reg, cnt_next;
  logic           right_reg, right_next;

  // Only shifts by a nonzero amount take the multi-cycle path.
  assign shift_start = ((Operation == OP_SLL) || (Operation == OP_SRL)) && (shamt != '0);
`else
  // Log-depth barrel shifters: stage gi conditionally shifts by 2**gi.
  logic [WIDTH-1:0] sll_stage [SHW+1];
  logic [WIDTH-1:0] srl_stage [SHW+1];

  assign sll_stage[0] = A;
  assign srl_stage[0] = A;

  genvar gi;
  generate
    for (gi = 0; gi < SHW; gi++) begin : g_barrel
      assign sll_stage[gi+1] = shamt[gi] ? (sll_stage[gi] << (1 << gi)) : sll_stage[gi];
      assign srl_stage[gi+1] = shamt[gi] ? (srl_stage[gi] >> (1 << gi)) : srl_stage[gi];
    end
  endgenerate

  assign shift_start = 1'b0;
`endif

  // Single-cycle result and overflow for the incoming request.
  always_comb begin
    sum         = A + B;
    diff        = A - B;
    calc_result = '0;
    calc_ovf    = 1'b0;
    case (Operation)
      OP_ADD, OP_ADDI: begin
        calc_result = sum;
        calc_ovf    = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB, OP_SUBI: begin
        calc_result = diff;
        calc_ovf    = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
      end
      OP_AND:  calc_result = A & B;
      OP_OR:   calc_result = A | B;
      OP_XOR:  calc_result = A ^ B;
      OP_SLTI: calc_result = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
`ifdef ALU_SERIAL_SHIFT_EN
      // Zero-amount shifts finish immediately; others go through SHIFT.
      OP_SLL, OP_SRL: calc_result = A;
`else
      OP_SLL: calc_result = sll_stage[SHW];
      OP_SRL: calc_result = srl_stage[SHW];
`endif
      default: calc_result = '0;
    endcase
  end

  // Next-state and next-output logic; Result doubles as the shift register.
  always_comb begin
    state_next  = state_reg;
    valid_next  = valid_reg;
    result_next = result_reg;
    zero_next   = zero_reg;
    ovf_next    = ovf_reg;
`ifdef ALU_SERIAL_SHIFT_EN
    cnt_next    = cnt_reg;
    right_next  = right_reg;
`endif
    case (state_reg)
      IDLE, DONE: begin
        if ((state_reg == DONE) && OutReady) begin
          state_next = IDLE;
          valid_next = 1'b0;
        end
        if (accept) begin
          if (shift_start) begin
            state_next  = SHIFT;
            valid_next  = 1'b0;
            result_next = A;
            zero_next   = 1'b0;
            ovf_next    = 1'b0;
`ifdef ALU_SERIAL_SHIFT_EN
            cnt_next    = shamt;
            right_next  = (Operation == OP_SRL);
`endif
          end else begin
            state_next  = DONE;
            valid_next  = 1'b1;
            result_next = calc_result;
            zero_next   = (calc_result == '0);
            ovf_next    = calc_ovf;
          end
        end
      end
`ifdef ALU_SERIAL_SHIFT_EN
      SHIFT: begin
        result_next = right_reg ? (result_reg >> 1) : (result_reg << 1);
        cnt_next    = cnt_reg - SHW'(1);
        if (cnt_reg == SHW'(1)) begin
          state_next = DONE;
          valid_next = 1'b1;
          zero_next  = (result_next == '0);
        end
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  // State and registered outputs; reset discards any operation in flight.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_reg  <= IDLE;
      valid_reg  <= 1'b0;
      result_reg <= '0;
      zero_reg   <= 1'b0;
      ovf_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      valid_reg  <= valid_next;
      result_reg <= result_next;
      zero_reg   <= zero_next;
      ovf_reg    <= ovf_next;
    end
  end

`ifdef ALU_SERIAL_SHIFT_EN
  // Remaining shift count and direction for the serial shifter.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      cnt_reg   <= '0;
      right_reg <= 1'b0;
    end else begin
      cnt_reg   <= cnt_next;
      right_reg <= right_next;
    end
  end
`endif

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed self-checking bench for alu_exec_unit (WIDTH=16).
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  op;
  logic [15:0] a, b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic        zero;
  logic        overflow;

  int checks   = 0;
  int failures = 0;

`ifdef ALU_SERIAL_SHIFT_EN
  localparam int LAT_SRL15 = 16;
  localparam int LAT_SLL4  = 5;
`else
  localparam int LAT_SRL15 = 1;
  localparam int LAT_SLL4  = 1;
`endif

  alu_exec_unit #(.WIDTH(16)) dut (
    .Clock    (clk),
    .Reset    (rst),
    .InValid  (in_valid),
    .InReady  (in_ready),
    .Operation(op),
    .A        (a),
    .B        (b),
    .OutValid (out_valid),
    .OutReady (out_ready),
    .Result   (result),
    .Zero     (zero),
    .Overflow (overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present a request for one edge, then drop InValid.
  task automatic issue(input logic [3:0] o, input logic [15:0] x, input logic [15:0] y);
    op = o; a = x; b = y; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Retire the pending result.
  task automatic retire();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  // Present a request and count edges until OutValid (bounded).
  task automatic issue_timed(input logic [3:0] o, input logic [15:0] x, input logic [15:0] y,
                             output int lat);
    op = o; a = x; b = y; in_valid = 1'b1;
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat++;
      if (out_valid) break;
    end
  endtask

  initial begin
    int lat;
    bit seen;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = 4'h0; a = '0; b = '0;
    #2;
    chk("rst_outvalid", {31'd0, out_valid}, 32'd0);
    chk("rst_result",   {16'd0, result},    32'd0);
    chk("rst_zero",     {31'd0, zero},      32'd0);
    chk("rst_ovf",      {31'd0, overflow},  32'd0);
    chk("rst_inready",  {31'd0, in_ready},  32'd1);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // ADD signed overflow
    issue(4'b0100, 16'h7FFF, 16'h0001);
    $display("txn ADD 7fff+0001 -> %h z=%b v=%b", result, zero, overflow);
    chk("add_valid",   {31'd0, out_valid}, 32'd1);
    chk("add_result",  {16'd0, result},    32'h8000);
    chk("add_ovf",     {31'd0, overflow},  32'd1);
    chk("add_zero",    {31'd0, zero},      32'd0);
    chk("add_inready", {31'd0, in_ready},  32'd0);
    retire();
    chk("retire_valid", {31'd0, out_valid}, 32'd0);

    // SUB to zero
    issue(4'b1100, 16'h0005, 16'h0005);
    $display("txn SUB 0005-0005 -> %h z=%b v=%b", result, zero, overflow);
    chk("sub_result", {16'd0, result},   32'd0);
    chk("sub_zero",   {31'd0, zero},     32'd1);
    chk("sub_ovf",    {31'd0, overflow}, 32'd0);
    retire();

    // SUBI with signed overflow
    issue(4'b1101, 16'h8000, 16'h0001);
    $display("txn SUBI 8000-0001 -> %h z=%b v=%b", result, zero, overflow);
    chk("subi_result", {16'd0, result},   32'h7FFF);
    chk("subi_ovf",    {31'd0, overflow}, 32'd1);
    retire();

    // ADDI with sign-extended immediate, no overflow
    issue(4'b0101, 16'h0003, 16'hFFFE);
    $display("txn ADDI 0003+fffe -> %h z=%b v=%b", result, zero, overflow);
    chk("addi_result", {16'd0, result},   32'h0001);
    chk("addi_ovf",    {31'd0, overflow}, 32'd0);
    retire();

    // SLTI signed compare
    issue(4'b0001, 16'hFFFF, 16'h0001);
    $display("txn SLTI ffff<0001 -> %h", result);
    chk("slti_neg_lt", {16'd0, result}, 32'd1);
    retire();
    issue(4'b0001, 16'h0001, 16'hFFFF);
    $display("txn SLTI 0001<ffff -> %h", result);
    chk("slti_pos_lt", {16'd0, result}, 32'd0);
    chk("slti_zero",   {31'd0, zero},   32'd1);
    retire();

    // AND
    issue(4'b0000, 16'hF0F0, 16'h0FF0);
    $display("txn AND f0f0&0ff0 -> %h", result);
    chk("and_result", {16'd0, result}, 32'h00F0);
    retire();

    // XOR held under backpressure while an OR request waits
    issue(4'b0011, 16'hF0F0, 16'h0FF0);
    $display("txn XOR f0f0^0ff0 -> %h", result);
    op = 4'b0010; a = 16'h1200; b = 16'h0034; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("xor_hold_result",  {16'd0, result},    32'hFF00);
      chk("xor_hold_valid",   {31'd0, out_valid}, 32'd1);
      chk("xor_hold_inready", {31'd0, in_ready},  32'd0);
      @(posedge clk); #1;
    end
    chk("xor_after_hold", {16'd0, result}, 32'hFF00);
    out_ready = 1'b1;
    #1;
    chk("handoff_inready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    $display("txn OR 1200|0034 -> %h", result);
    chk("or_valid",  {31'd0, out_valid}, 32'd1);
    chk("or_result", {16'd0, result},    32'h1234);

    // Back-to-back with OutReady high: one op per cycle
    op = 4'b0100; a = 16'h0001; b = 16'h0002; in_valid = 1'b1;
    @(posedge clk); #1;
    $display("txn ADD 0001+0002 -> %h", result);
    chk("b2b_first", {16'd0, result}, 32'h0003);
    op = 4'b0011; a = 16'h00FF; b = 16'h0F0F;
    @(posedge clk); #1;
    in_valid = 1'b0;
    $display("txn XOR 00ff^0f0f -> %h", result);
    chk("b2b_second", {16'd0, result},    32'h0FF0);
    chk("b2b_valid",  {31'd0, out_valid}, 32'd1);
    @(posedge clk); #1;
    chk("b2b_drain", {31'd0, out_valid}, 32'd0);
    out_ready = 1'b0;

    // Illegal operation code
    issue(4'b1111, 16'h1234, 16'h5678);
    $display("txn ILL 1111 -> %h z=%b v=%b", result, zero, overflow);
    chk("ill_valid",  {31'd0, out_valid}, 32'd1);
    chk("ill_result", {16'd0, result},    32'd0);
    chk("ill_zero",   {31'd0, zero},      32'd1);
    chk("ill_ovf",    {31'd0, overflow},  32'd0);
    retire();

    // Shifts: latency depends on build, result does not
    issue_timed(4'b0111, 16'h8000, 16'h000F, lat);
    $display("txn SRL 8000>>15 -> %h lat=%0d", result, lat);
    chk("srl_latency", lat, LAT_SRL15);
    chk("srl_result",  {16'd0, result}, 32'h0001);
    chk("srl_zero",    {31'd0, zero},   32'd0);
    retire();
    issue_timed(4'b0110, 16'h0003, 16'h0004, lat);
    $display("txn SLL 0003<<4 -> %h lat=%0d", result, lat);
    chk("sll_latency", lat, LAT_SLL4);
    chk("sll_result",  {16'd0, result}, 32'h0030);
    retire();
    issue_timed(4'b0110, 16'hABCD, 16'h0010, lat);
    $display("txn SLL abcd<<0 -> %h lat=%0d", result, lat);
    chk("sll0_latency", lat, 1);
    chk("sll0_result",  {16'd0, result}, 32'hABCD);
    retire();
    issue_timed(4'b0111, 16'h0001, 16'h0001, lat);
    $display("txn SRL 0001>>1 -> %h z=%b lat=%0d", result, zero, lat);
    chk("srl_to_zero", {16'd0, result}, 32'd0);
    chk("srl_zero_flag", {31'd0, zero}, 32'd1);
    retire();

    // Reset in the middle of a long shift
    op = 4'b0110; a = 16'h0001; b = 16'h000F; in_valid = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      if (out_valid) seen = 1'b1;
    end
`ifdef ALU_SERIAL_SHIFT_EN
    chk("shift_not_done_yet", {31'd0, seen}, 32'd0);
`endif
    #2;
    rst = 1'b1;
    #1;
    $display("txn RESET mid-shift -> valid=%b result=%h ready=%b", out_valid, result, in_ready);
    chk("midrst_valid",   {31'd0, out_valid}, 32'd0);
    chk("midrst_result",  {16'd0, result},    32'd0);
    chk("midrst_inready", {31'd0, in_ready},  32'd1);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    chk("midrst_no_result", {31'd0, seen}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
